// File: rtl/sigma_delta_adc_pkg.sv
// sigma_delta_adc_pkg: shared audio-path types and width helpers for the sigma-delta capture path
package sigma_delta_adc_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    function automatic int width(input int msbi);
        return msbi + 1;
    endfunction

    function automatic int window(input int msbi);
        return 2 ** (msbi + 1);
    endfunction

endpackage

// File: rtl/sigma_delta_adc_sync_bit.sv
// sync_bit: SYNC-deep single-bit synchroniser for asynchronous board inputs (comparator, ear)
module sync_bit #(
    parameter int SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] r;

    always_ff @(posedge clock or negedge reset)
        if (!reset) r <= '0;
        else r <= {r[SYNC-2:0], d};

    assign q = r[SYNC-1];

endmodule

// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: first-order sigma-delta ADC; drives RC feedback, decimates ones-count into a handshaked sample
module sigma_delta_adc
    import sigma_delta_adc_pkg::*;
#(
    parameter int MSBI = 5,
    parameter int SYNC = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          en,
    input  logic          cmp,
    output logic          fb,
    output logic [MSBI:0] dout,
    output logic          valid,
    input  logic          ready,
    output logic          ovr,
    input  logic          clear
);

    localparam int W = width(MSBI);

    state_t         state, state_nx;
    logic           cmp_s, fb_nx, step, wrap, deliver, set_ovr;
    logic [W-1:0]   cnt, cnt_nx, sample;
    logic [W:0]     acc, acc_nx, sum;

    sync_bit #(.SYNC(SYNC)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (cmp),
        .q     (cmp_s)
    );

    // a full window of ones reaches N, which does not fit W bits and is clamped
    assign sum     = acc + {{W{1'b0}}, fb};
    assign sample  = sum[W] ? '1 : sum[W-1:0];
    assign step    = en && ce && state != IDLE;
    assign wrap    = step && cnt == '1;
    assign deliver = wrap && state == RUN;
    assign set_ovr = deliver && valid && !ready;

    always_comb begin
        state_nx = state;
        fb_nx    = fb;
        cnt_nx   = cnt;
        acc_nx   = acc;
        if (!en) begin
            state_nx = IDLE;
            fb_nx    = 1'b0;
            cnt_nx   = '0;
            acc_nx   = '0;
        end else if (state == IDLE) begin
            state_nx = SETTLE;
        end else if (step) begin
            fb_nx    = ~cmp_s;
            cnt_nx   = cnt + 1'b1;
            acc_nx   = wrap ? '0 : sum;
            state_nx = wrap ? RUN : state;
        end
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            fb    <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            fb    <= fb_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
        end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            dout  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (deliver) begin
                dout  <= sample;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            ovr <= set_ovr || (ovr && !clear);
        end

endmodule

// File: doc/sigma_delta_adc.md
Name: sigma_delta_adc

Overview:
- First-order sigma-delta ADC for the tape/audio input path. It is the capture counterpart of the 1-bit sigma-delta DAC output path.
- Drives a 1-bit feedback pin into an external RC integrator and samples an external comparator.
- Counts feedback ones over a fixed decimation window and presents an unsigned (MSBI+1)-bit sample under a valid/ready handshake.
- Sits between the board comparator pin and the tape decoder / audio mixer.

Parameters:
- MSBI, 5: MSB index of sample output. Width W = MSBI+1. Window N = 2^W ce-cycles.
- SYNC, 2: number of synchroniser flops on cmp, minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce     in  1  modulator clock enable; one modulator step per ce-high cycle
- en     in  1  converter enable
- cmp    in  1  comparator output; asynchronous; 1 = integrator above input
- fb     out 1  feedback to RC integrator
- do     out W  sample data
- valid  out 1  do holds an unconsumed sample
- ready  in  1  consumer accepts do when valid&ready
- ovr    out 1  sticky overrun flag
- clear  in  1  clears ovr

Behaviour:
- Reset (reset=0, async): fb=0, do=0, valid=0, ovr=0, state=IDLE, cnt=0, acc=0, sync chain=0.
- Synchroniser: cmp passes through SYNC flops every clock, independent of ce. The result is cmp_s.
- Modulator, on each ce-high cycle in SETTLE or RUN:
  - fb <= ~cmp_s (registered).
  - acc accumulates the value of fb before this update, i.e. the bit currently driven.
  - cnt increments, W-bit, wraps N-1 -> 0.
- FSM:
  - IDLE: fb=0, cnt=0, acc=0. Leaves on en=1 to SETTLE, at the next clock.
  - SETTLE: runs exactly one full window (N ce-steps). No sample is produced. At the wrap, acc=0 and the FSM moves to RUN.
  - RUN: at each ce step with cnt==N-1, the window ends:
    - sample = acc + fb, saturated to N-1. acc is W+1 bits internally; the count of N is clamped to N-1.
    - acc <= 0.
    - The sample is delivered to the output register in the same clock.
  - Any state with en=0: IDLE at the next clock. fb=0, cnt and acc cleared. do, valid and ovr are unchanged.
- Output register / handshake:
  - Accept = valid & ready.
  - Delivery with valid=0, or coinciding with an accept: do <= sample, valid <= 1.
  - Delivery with valid=1 and no accept: do overwritten, valid stays 1, ovr <= 1.
  - Accept without delivery: valid <= 0 next clock. do holds its value.
  - Latency: do/valid update on the clock edge that processes the last ce step of the window.
- ovr:
  - Set only by an overwrite; cleared by clear=1.
  - clear and a set in the same clock: set wins.
- ce=0: no state change except the synchroniser and the handshake/clear logic.
- Reset asserted mid-window: everything returns to reset values immediately. After release, the full SETTLE window repeats before the first sample.

Decomposition:
- Shared audio package:
  - FSM state enum: IDLE, SETTLE, RUN.
  - Width helper W = MSBI+1.
  - Window constant N = 2^W.
- One natural sub-module: sync_bit, the SYNC-deep synchroniser with async active-low reset. It is reusable for the ear input.
- Modulator/decimator and handshake stay in the top module.

Test Plan:
- cmp=0 constant, ce=1, en=1, ready=1 -> fb=1 from the first ce step. First valid after 2N+1 clocks, then every N clocks. do=63, saturated (W=6).
- cmp=1 constant -> fb=0. Every sample do=0. ovr stays 0.
- Behavioural RC+comparator model with input at 25% of full scale -> after settling, do within 16±1 across 20 consecutive samples. fb ones-density ≈0.25.
- ready=0 for 2 windows after the first valid -> ovr=1 after the second delivery, do=latest sample. Then ready=1 for one clock -> valid=0 next clock. clear=1 -> ovr=0. clear coincident with a new overwrite -> ovr remains 1.
- reset pulsed low for 1 clock at cnt=30 of a RUN window:
  - All outputs return to 0 immediately, asynchronously, without a clock edge.
  - After release, no valid until SETTLE+RUN windows complete (2N ce steps).
- en dropped mid-RUN with valid=1 -> fb=0 next clock, do/valid retained. en re-raised -> the SETTLE window repeats before the next sample.
